acc_unit: RTL
=============

ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 The module SHALL take parameter N_CORE, default N_CORE from the shared package, meaning the number of requesting cores.
REQ-002 The module SHALL take parameter N_ACC, default N_ACC from the shared package, meaning the number of shared accumulators.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 clear  input  1  one-cycle pulse that zeroes all accumulators; driven from issue_fork.
REQ-006 req_valid  input  [N_CORE][N_ACC]  core i requests an add into accumulator j.
REQ-007 req_data  input  [N_CORE][N_ACC] x 32  two's-complement addend.
REQ-008 req_ready  output  [N_CORE][N_ACC]  grant; an add is accepted when valid and ready are both high in the same cycle.
REQ-009 acc_data  output  [N_ACC] x 32  committed accumulator value, broadcast to all cores.
REQ-010 acc_count  output  [N_ACC] x 16  number of adds committed since the last clear or reset.
REQ-011 idle  output  1  high when no add is in flight in any pipeline stage.

Function
REQ-012 Each accumulator j SHALL have an independent round-robin arbiter granting at most one core per cycle.
REQ-013 req_ready[i][j] SHALL be combinational from req_valid[*][j], the arbiter pointer and clear.
REQ-014 The arbiter pointer SHALL start at core 0 and, after a grant to core k, SHALL move to (k+1) mod N_CORE; with no grant it SHALL hold.
REQ-015 A core SHALL see ready only while asserting valid; at most one ready per accumulator per cycle.
REQ-016 Pipeline: stage S1 SHALL register the granted addend and a valid bit; stage S2 SHALL perform acc <= acc + S1 data.
REQ-017 Latency: an add accepted at cycle t SHALL be visible on acc_data and acc_count at cycle t+2.
REQ-018 Back-to-back accepted adds to one accumulator SHALL all be applied, one per cycle, with no stall and no loss.
REQ-019 Addition SHALL be 32-bit modular; overflow wraps silently (0x7FFFFFFF + 1 = 0x80000000).
REQ-020 acc_count SHALL saturate at 0xFFFF.
REQ-021 When clear is high, all req_ready SHALL be 0, all S1 valid bits SHALL be dropped, and every acc_data and acc_count SHALL be 0 on the following cycle.
REQ-022 An add already in S1 on a clear cycle SHALL be discarded, not applied.
REQ-023 Arbiter pointers SHALL be unaffected by clear.
REQ-024 idle SHALL be the NOR of all S1 valid bits.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL set acc_data=0, acc_count=0, S1 valid=0 and arbiter pointers=0; idle then reads 1.
REQ-026 While rst is high, req_ready SHALL be 0; rst SHALL take priority over clear.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight adds.

Structure
REQ-028 N_CORE, N_ACC and the 32-bit data width SHALL come from the shared common package; no local redefinition.
REQ-029 The round-robin arbiter SHALL be one sub-module, rr_arbiter (N-way, request vector in, one-hot grant out, pointer internal), instantiated N_ACC times.
REQ-030 The top level SHALL generate-loop over accumulators; no per-core special cases.

Verification
REQ-031 Test 1: reset, then core 0 sends 5 to acc 0 once -> acc_data[0]=5 and acc_count[0]=1 two cycles after acceptance; idle low for exactly one cycle.
REQ-032 Test 2: all 4 cores hold valid on acc 0 with values 1, 2, 3, 4 -> grants in order 0, 1, 2, 3 on consecutive cycles; final acc_data[0]=10, acc_count[0]=4.
REQ-033 Test 3: with the pointer at 2, cores 0 and 3 request -> core 3 is granted first, then core 0.
REQ-034 Test 4: acc 0 = 0x7FFFFFFF, then add 1 -> 0x80000000, count incremented.
REQ-035 Test 5: add accepted at cycle t, clear at t+1 -> acc_data=0 and acc_count=0 at t+2; the add is never applied; req_ready=0 during the clear cycle.
REQ-036 Test 6: concurrent requests on acc 0 and acc 1 from different cores -> both accepted in the same cycle; the accumulators update independently.

Source files
------------

// File: rtl/acc_unit_pkg.sv
// acc_unit_pkg: shared sizes, types and helpers for the accumulator unit
package acc_unit_pkg;
  localparam int N_CORE = 4;
  localparam int N_ACC = 2;
  localparam int DATA_W = 32;
  localparam int CNT_W = 16;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic v;
    data_t d;
  } s1_t;
  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + cnt_t'(1);
  endfunction
endpackage

// File: rtl/acc_unit_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with one-hot grant and internal pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb begin
    gnt = '0;
    ptr_d = ptr_q;
    for (int k = 2 * N - 1; k >= 0; k--)
      if (req[k % N] && ((k < N) == ((k % N) >= int'(ptr_q)))) begin
        gnt = '0;
        gnt[k % N] = 1'b1;
        ptr_d = (k % N == N - 1) ? '0 : PW'(k % N + 1);
      end
  end
  always_ff @(posedge clk)
    ptr_q <= rst ? '0 : ptr_d;
endmodule

// File: rtl/acc_unit.sv
// acc_unit: shared accumulators fed by round-robin arbitrated cores through a two-stage pipeline
module acc_unit
  import acc_unit_pkg::*;
#(
  parameter int N_CORE = acc_unit_pkg::N_CORE,
  parameter int N_ACC = acc_unit_pkg::N_ACC
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic [N_CORE-1:0][N_ACC-1:0]             req_valid,
  input  logic [N_CORE-1:0][N_ACC-1:0][DATA_W-1:0] req_data,
  output logic [N_CORE-1:0][N_ACC-1:0]             req_ready,
  output data_t [N_ACC-1:0]                       acc_data,
  output cnt_t  [N_ACC-1:0]                       acc_count,
  output logic                                   idle
);
  logic [N_ACC-1:0] busy;
  genvar i, j;
  for (j = 0; j < N_ACC; j++) begin : g_acc
    logic [N_CORE-1:0] req, gnt;
    s1_t s1_q, s1_d;
    data_t acc_q, acc_d;
    cnt_t cnt_q, cnt_d;
    for (i = 0; i < N_CORE; i++) begin : g_core
      assign req[i] = req_valid[i][j] & ~clear & ~rst;
      assign req_ready[i][j] = gnt[i];
    end
    rr_arbiter #(.N(N_CORE)) u_arb (
      .clk(clk),
      .rst(rst),
      .req(req),
      .gnt(gnt)
    );
    always_comb begin
      s1_d = '0;
      for (int k = 0; k < N_CORE; k++)
        if (gnt[k]) s1_d = '{v: 1'b1, d: req_data[k][j]};
      acc_d = clear ? '0 : s1_q.v ? acc_q + s1_q.d : acc_q;
      cnt_d = clear ? '0 : s1_q.v ? sat_inc(cnt_q) : cnt_q;
    end
    always_ff @(posedge clk)
      if (rst) begin
        s1_q <= '0;
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        s1_q <= s1_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
    assign acc_data[j] = acc_q;
    assign acc_count[j] = cnt_q;
    assign busy[j] = s1_q.v;
  end
  assign idle = ~|busy;
endmodule
